dpram_be_clr: RTL and testbench
===============================

// Module: dpram_be_clr
// PURPOSE
//  Single-clock true dual-port RAM with per-byte write enables, a selectable read-during-write mode,
//  cross-port write-collision arbitration and a hardware clear sweep. The sweep runs after reset
//  and on request. Drop-in successor for the PPU/APU/mapper scratch RAMs: ports A and B are
//  symmetric. The clear engine guarantees deterministic contents after every reset or console reset.
// PARAMETERS
//  ADDR_W     10  address width; depth = 2**ADDR_W words
//  DATA_W     16  word width; must be a multiple of 8 (elaboration error otherwise)
//  RDW_MODE   0   same-port read-during-write: 0 = no-change (q holds), 1 = write-through (q = new data)
//  CLEAR_VAL  0   DATA_W-bit value written to every word by the clear sweep
// PORTS
//  clk        in   1         system clock, all logic rising-edge
//  resetn     in   1         asynchronous active-low reset
//  clear_req  in   1         1-cycle pulse: (re)start clear sweep
//  busy       out  1         1 while clear sweep active; port accesses ignored
//  addr_a     in   ADDR_W    port A address
//  din_a      in   DATA_W    port A write data
//  we_a       in   1         port A write strobe
//  be_a       in   DATA_W/8  port A byte enables (bit i -> din_a[8i+7:8i])
//  q_a        out  DATA_W    port A read data
//  addr_b/din_b/we_b/be_b/q_b  same as port A, for port B
//  coll       out  1         1-cycle pulse: A and B wrote same address with overlapping byte enables
// BEHAVIOUR
//  Reset (resetn=0): q_a=q_b=0, coll=0, busy=1, FSM=CLEAR, sweep pointer=0. Memory is not reset directly.
//  FSM CLEAR: each cycle writes CLEAR_VAL to mem[ptr], then ptr++. At ptr=2**ADDR_W-1 the FSM writes
//   and goes to IDLE. busy=0 from the next edge. A sweep therefore takes exactly 2**ADDR_W cycles.
//  FSM IDLE: clear_req=1 -> CLEAR with ptr=0, and busy=1 next cycle. clear_req while in CLEAR restarts at ptr=0.
//  While busy: we_a/we_b dropped, q_a/q_b hold last value, coll=0.
//  Read (IDLE, we_x=0): q_x <= mem[addr_x], latency 1 cycle.
//  Write (IDLE, we_x=1): bytes with be_x[i]=1 updated; bytes with be_x[i]=0 keep old content.
//   we_x=1 with be_x=0 changes no memory.
//   RDW_MODE=0: q_x holds. RDW_MODE=1: q_x <= merged word (new bytes where enabled, old bytes elsewhere).
//  Cross-port read while the other port writes the same address: the reader gets the OLD word (read-first).
//  Dual write, same address: per byte, A wins where be_a[i]=1, otherwise B's byte where be_b[i]=1.
//   coll=1 next cycle iff (be_a & be_b)!=0. Disjoint enables merge cleanly with coll=0.
//  Dual write, different addresses: independent, coll=0.
//  resetn asserted mid-sweep or mid-access: outputs return to reset values immediately. Sweep restarts at 0
//   after release. Words already cleared or written are not guaranteed beyond that.
//  Address wrap: none needed; ADDR_W-bit addresses cover the full depth exactly.
// CONFIGURATION
//  DPRAM_OUTREG_EN defined: extra output register on q_a/q_b and coll; read latency 2, coll 2 cycles after
//   the write. Registers reset to 0 and hold while busy. Write-through data is also delayed 1 extra cycle.
//  Not defined: latency 1 as above; no extra flops.
// TESTING (ADDR_W=4, DATA_W=16, RDW_MODE=0, CLEAR_VAL=16'hA5A5, macro off unless stated)
//  1 Release resetn -> busy=1 for exactly 16 cycles. Then read addr 0..15 -> every q = 16'hA5A5.
//  2 A writes 16'h1234 be=2'b11 @3. Then A writes 16'hFF00 be=2'b10 @3. B reads @3 -> q_b=16'hFF34 after 1 cycle.
//  3 Same cycle: A writes 16'h1111 be=11 @5, B writes 16'h2222 be=01 @5 -> coll=1 next cycle. Read @5 -> 16'h1111.
//    Repeat with be_a=10, be_b=01 -> coll=0, read -> 16'h1122.
//  4 A writes 16'hBEEF @7 while B reads @7 in the same cycle -> q_b=old value 16'hA5A5.
//    A's q_a unchanged (RDW_MODE=0). With RDW_MODE=1 -> q_a=16'hBEEF.
//  5 clear_req at sweep ptr=9 -> sweep restarts, busy stays 1 for 16 more cycles, all words 16'hA5A5.
//    Writes issued while busy have no effect.
//  6 DPRAM_OUTREG_EN: write 16'h0F0F @2, then read @2 -> q_a=16'h0F0F exactly 2 cycles after the read.
//    Assert resetn mid-read -> q_a=0 immediately.

Source files
------------

// File: rtl/dpram_be_clr.sv
// dpram_be_clr -- single-clock true dual-port RAM with per-byte write enables,
// selectable same-port read-during-write behaviour, cross-port write-collision
// arbitration and a hardware clear sweep that runs after reset and on request.
//
// Ports
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   clear_req              1-cycle pulse, (re)starts the clear sweep at word 0
//   busy                   high while the sweep owns the array; port accesses ignored
//   addr_x/din_x/we_x/be_x port x (a|b) address, write data, write strobe, byte enables
//   q_x                    port x read data
//   coll                   pulse: both ports wrote one address with overlapping bytes
//
// Optional feature (macro DPRAM_OUTREG_EN): adds one output register stage on
// q_a/q_b/coll, making read latency 2. Without it, latency is 1 and no extra flops.
module dpram_be_clr #(
    parameter int                ADDR_W    = 10,
    parameter int                DATA_W    = 16,
    parameter int                RDW_MODE  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                clear_req,
    output logic                busy,
    input  logic [ADDR_W-1:0]   addr_a,
    input  logic [DATA_W-1:0]   din_a,
    input  logic                we_a,
    input  logic [DATA_W/8-1:0] be_a,
    output logic [DATA_W-1:0]   q_a,
    input  logic [ADDR_W-1:0]   addr_b,
    input  logic [DATA_W-1:0]   din_b,
    input  logic                we_b,
    input  logic [DATA_W/8-1:0] be_b,
    output logic [DATA_W-1:0]   q_b,
    output logic                coll
);
    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("dpram_be_clr: DATA_W must be a multiple of 8");
    end

    typedef enum logic {S_CLEAR, S_IDLE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_a, rd_b, wt_a, wt_b;
    logic [DATA_W-1:0] q_a_i, q_b_i;
    logic              coll_i;
    logic              wr_a, wr_b;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            S_CLEAR: begin
                if (clear_req) begin
                    ptr_nxt = '0;                 // restart from the bottom
                end else if (ptr == {ADDR_W{1'b1}}) begin
                    state_nxt = S_IDLE;           // last word written this cycle
                    ptr_nxt   = '0;
                end else begin
                    ptr_nxt = ptr + 1'b1;
                end
            end
            S_IDLE: begin
                if (clear_req) begin
                    state_nxt = S_CLEAR;
                    ptr_nxt   = '0;
                end
            end
            default: begin
                state_nxt = S_CLEAR;
                ptr_nxt   = '0;
            end
        endcase
    end

    assign busy = (state == S_CLEAR);
    assign wr_a = we_a & ~busy;
    assign wr_b = we_b & ~busy;

    // ---------------- array ----------------
    // B's bytes are scheduled first so that A's later assignment wins on any
    // byte both ports enable at the same address.
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[ptr] <= CLEAR_VAL;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (wr_b && be_b[i]) mem[addr_b][8*i +: 8] <= din_b[8*i +: 8];
                if (wr_a && be_a[i]) mem[addr_a][8*i +: 8] <= din_a[8*i +: 8];
            end
        end
    end

    // Old word plus this port's enabled bytes, used for write-through.
    always_comb begin
        rd_a = mem[addr_a];
        rd_b = mem[addr_b];
        wt_a = rd_a;
        wt_b = rd_b;
        for (int i = 0; i < NB; i++) begin
            if (be_a[i]) wt_a[8*i +: 8] = din_a[8*i +: 8];
            if (be_b[i]) wt_b[8*i +: 8] = din_b[8*i +: 8];
        end
    end

    // Reads sample the array before this edge's writes land (read-first).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_a_i  <= '0;
            q_b_i  <= '0;
            coll_i <= 1'b0;
        end else begin
            coll_i <= wr_a & wr_b & (addr_a == addr_b) & (|(be_a & be_b));
            if (!busy) begin
                if (!we_a)              q_a_i <= rd_a;
                else if (RDW_MODE == 1) q_a_i <= wt_a;
                if (!we_b)              q_b_i <= rd_b;
                else if (RDW_MODE == 1) q_b_i <= wt_b;
            end
        end
    end

`ifdef DPRAM_OUTREG_EN
    logic [DATA_W-1:0] q_a_o, q_b_o;
    logic              coll_o;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_a_o  <= '0;
            q_b_o  <= '0;
            coll_o <= 1'b0;
        end else begin
            coll_o <= coll_i & ~busy;
            if (!busy) begin
                q_a_o <= q_a_i;
                q_b_o <= q_b_i;
            end
        end
    end

    assign q_a  = q_a_o;
    assign q_b  = q_b_o;
    assign coll = coll_o;
`else
    assign q_a  = q_a_i;
    assign q_b  = q_b_i;
    assign coll = coll_i;
`endif

endmodule

// File: tb/tb_dpram_be_clr.sv
// Scoreboard bench for dpram_be_clr (ADDR_W=4, DATA_W=16, CLEAR_VAL=A5A5).
// Two instances share all inputs: dut (no-change read-during-write) and
// dut_wt (write-through). Expected values are queued when stimulus is driven
// and compared on the falling edge where the output becomes due.
module tb_dpram_be_clr;
`ifdef DPRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk, resetn, clear_req;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] din_a, din_b;
    logic        we_a, we_b;
    logic [1:0]  be_a, be_b;
    logic [15:0] q_a, q_b, q_a1, q_b1;
    logic        coll, coll1, busy, busy1;

    dpram_be_clr #(.ADDR_W(4), .DATA_W(16), .RDW_MODE(0), .CLEAR_VAL(16'hA5A5)) dut (
        .clk(clk), .resetn(resetn), .clear_req(clear_req), .busy(busy),
        .addr_a(addr_a), .din_a(din_a), .we_a(we_a), .be_a(be_a), .q_a(q_a),
        .addr_b(addr_b), .din_b(din_b), .we_b(we_b), .be_b(be_b), .q_b(q_b),
        .coll(coll));

    dpram_be_clr #(.ADDR_W(4), .DATA_W(16), .RDW_MODE(1), .CLEAR_VAL(16'hA5A5)) dut_wt (
        .clk(clk), .resetn(resetn), .clear_req(clear_req), .busy(busy1),
        .addr_a(addr_a), .din_a(din_a), .we_a(we_a), .be_a(be_a), .q_a(q_a1),
        .addr_b(addr_b), .din_b(din_b), .we_b(we_b), .be_b(be_b), .q_b(q_b1),
        .coll(coll1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // kind: 0 q_a, 1 q_b, 2 coll, 3 q_a (write-through), 4 q_b (write-through), 5 coll (write-through)
    typedef struct {
        string       tag;
        int          kind;
        logic [15:0] exp;
        int          due;
    } sb_t;
    sb_t sb[$];

    task automatic push(input string tag, input int kind, input logic [15:0] exp);
        sb_t e;
        e.tag = tag; e.kind = kind; e.exp = exp; e.due = cyc + LAT;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] obs(input int kind);
        case (kind)
            0:       return q_a;
            1:       return q_b;
            2:       return {15'b0, coll};
            3:       return q_a1;
            4:       return q_b1;
            5:       return {15'b0, coll1};
            default: return 16'hxxxx;
        endcase
    endfunction

    always @(negedge clk) begin : mon
        sb_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk(e.tag, obs(e.kind), e.exp);
        end
    end

    task automatic op(input logic wa, input logic [3:0] aa, input logic [15:0] da, input logic [1:0] ba,
                      input logic wb, input logic [3:0] ab, input logic [15:0] db, input logic [1:0] bb);
        @(negedge clk);
        we_a = wa; addr_a = aa; din_a = da; be_a = ba;
        we_b = wb; addr_b = ab; din_b = db; be_b = bb;
    endtask

    // Busy-high cycles counted from the current falling edge; bounded.
    task automatic busy_len(input string tag, input int want);
        int n = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            n++;
            chk({tag, "_coll"}, coll, 0);
            @(negedge clk);
        end
        chk(tag, n, want);
    endtask

    initial begin
        resetn = 1'b0; clear_req = 1'b0;
        we_a = 0; addr_a = 0; din_a = 0; be_a = 0;
        we_b = 0; addr_b = 0; din_b = 0; be_b = 0;
        #3;
        chk("rst_q_a", q_a, 0);
        chk("rst_q_b", q_b, 0);
        chk("rst_coll", coll, 0);
        chk("rst_busy", busy, 1);
        chk("rst_busy_wt", busy1, 1);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        busy_len("init_busy_len", 16);

        // every word holds the clear value
        for (int i = 0; i < 16; i++) begin
            op(0, 4'(i), 0, 0, 0, 4'(15 - i), 0, 0);
            push("init_rd_a", 0, 16'hA5A5);
            push("init_rd_b", 1, 16'hA5A5);
        end

        // byte-enable merge; q_a holds during own writes
        op(1, 3, 16'h1234, 2'b11, 0, 0, 0, 0);
        push("wr_hold_a", 0, 16'hA5A5);
        push("wr_thru_a", 3, 16'h1234);
        op(1, 3, 16'hFF00, 2'b10, 0, 0, 0, 0);
        push("wr_hold_a2", 0, 16'hA5A5);
        push("wr_thru_a2", 3, 16'hFF34);
        op(0, 0, 0, 0, 0, 3, 0, 0);
        push("be_merge_b", 1, 16'hFF34);
        push("be_merge_b_wt", 4, 16'hFF34);

        // dual write, same address, overlapping then disjoint enables
        op(1, 5, 16'h1111, 2'b11, 1, 5, 16'h2222, 2'b01);
        push("coll_ovl", 2, 1);
        push("coll_ovl_wt", 5, 1);
        op(0, 5, 0, 0, 0, 0, 0, 0);
        push("coll_ovl_rd", 0, 16'h1111);
        push("coll_ovl_clr", 2, 0);
        op(1, 5, 16'h1111, 2'b10, 1, 5, 16'h2222, 2'b01);
        push("coll_disj", 2, 0);
        op(0, 5, 0, 0, 0, 5, 0, 0);
        push("disj_rd_a", 0, 16'h1122);
        push("disj_rd_b", 1, 16'h1122);

        // cross-port read-first, same-port no-change vs write-through
        op(1, 7, 16'hBEEF, 2'b11, 0, 7, 0, 0);
        push("xrd_old_b", 1, 16'hA5A5);
        push("xrd_old_b_wt", 4, 16'hA5A5);
        push("rdw_hold_a", 0, 16'h1122);
        push("rdw_thru_a", 3, 16'hBEEF);
        op(0, 7, 0, 0, 0, 0, 0, 0);
        push("rd7_a", 0, 16'hBEEF);

        // dual write, different addresses
        op(1, 8, 16'h1357, 2'b11, 1, 9, 16'h2468, 2'b11);
        push("diff_coll", 2, 0);
        op(0, 8, 0, 0, 0, 9, 0, 0);
        push("diff_rd_a", 0, 16'h1357);
        push("diff_rd_b", 1, 16'h2468);

        // be=0 writes nothing; single low byte
        op(1, 10, 16'hFFFF, 2'b00, 1, 11, 16'h00CC, 2'b01);
        push("be0_thru_a", 3, 16'hA5A5);
        op(0, 10, 0, 0, 0, 11, 0, 0);
        push("be0_rd", 0, 16'hA5A5);
        push("lo_byte_rd", 1, 16'hA5CC);
        op(0, 11, 0, 0, 0, 0, 0, 0);
        push("lo_byte_rd_a", 0, 16'hA5CC);
        repeat (3) @(negedge clk);

        // clear request, restart mid-sweep, writes while busy ignored
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        chk("clr_busy", busy, 1);
        repeat (9) @(negedge clk);
        clear_req = 1'b1;
        we_a = 1; addr_a = 2; din_a = 16'h0000; be_a = 2'b11;
        we_b = 1; addr_b = 2; din_b = 16'h0000; be_b = 2'b11;
        @(negedge clk);
        clear_req = 1'b0;
        busy_len("restart_busy_len", 16);
        we_a = 0; we_b = 0;
        chk("busy_hold_q_a", q_a, 16'hA5CC);
        for (int i = 0; i < 16; i++) begin
            op(0, 4'(i), 0, 0, 0, 4'(15 - i), 0, 0);
            push("clr_rd_a", 0, 16'hA5A5);
            push("clr_rd_b", 1, 16'hA5A5);
        end

        // read latency, then reset mid-read
        op(1, 2, 16'h0F0F, 2'b11, 0, 0, 0, 0);
        op(0, 2, 0, 0, 0, 0, 0, 0);
        push("lat_rd_a", 0, 16'h0F0F);
        op(0, 3, 0, 0, 0, 3, 0, 0);
        repeat (LAT + 2) @(negedge clk);
        op(0, 2, 0, 0, 0, 2, 0, 0);
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("midrd_rst_q_a", q_a, 0);
        chk("midrd_rst_q_b", q_b, 0);
        chk("midrd_rst_coll", coll, 0);
        chk("midrd_rst_busy", busy, 1);
        @(negedge clk);
        resetn = 1'b1;
        busy_len("rst2_busy_len", 16);
        op(0, 2, 0, 0, 0, 0, 0, 0);
        push("rst2_rd_a", 0, 16'hA5A5);
        repeat (LAT + 2) @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
